// File: rtl/keypad_display_master.sv
// rtl/keypad_display_master.sv - keypad poller driving an 8-digit BCD display register
// Polls the keypad register, edge-detects presses, and writes the display buffer on change.
module keypad_display_master #(
  parameter int          POLL_INTERVAL = 1000,
  parameter logic [3:0]  KEY_ADDR      = 4'h0,
  parameter logic [3:0]  DISP_ADDR     = 4'h4,
  parameter logic [3:0]  IDLE_ADDR     = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [3:0]  address,
  output logic [31:0] wdata,
  output logic        writeEnable,
  input  logic [31:0] rdata,
  output logic [31:0] display_value,
  output logic [7:0]  key_count,
  output logic        busy
);

  localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_DECODE, S_WR} state_t;

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_code, w_code_next;
  logic          r_last_valid, w_last_valid_next;
  logic [7:0]    r_last_code, w_last_code_next;
  logic [31:0]   w_disp_next, w_wdata_next;
  logic [7:0]    w_kc_next;
  logic [3:0]    w_addr_next;
  logic          w_we_next;
  logic          w_accept;
  logic [3:0]    w_key;
  logic          w_unused_rdata;

  assign w_unused_rdata = ^{rdata[31:8], rdata[6:4]};
  assign w_key    = r_code[3:0];
  assign w_accept = r_code[7] && (!r_last_valid || (r_code != r_last_code));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_code        <= '0;
      r_last_valid  <= 1'b0;
      r_last_code   <= '0;
      address       <= IDLE_ADDR;
      wdata         <= '0;
      writeEnable   <= 1'b0;
      display_value <= '0;
      key_count     <= '0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_code        <= w_code_next;
      r_last_valid  <= w_last_valid_next;
      r_last_code   <= w_last_code_next;
      address       <= w_addr_next;
      wdata         <= w_wdata_next;
      writeEnable   <= w_we_next;
      display_value <= w_disp_next;
      key_count     <= w_kc_next;
      busy          <= (w_next_state != S_IDLE);
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_cnt_next        = r_cnt;
    w_code_next       = r_code;
    w_last_valid_next = r_last_valid;
    w_last_code_next  = r_last_code;
    w_disp_next       = display_value;
    w_kc_next         = key_count;
    w_addr_next       = IDLE_ADDR;
    w_wdata_next      = wdata;
    w_we_next         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          if (r_cnt == LAST_CNT) begin
            w_cnt_next   = '0;
            w_next_state = S_RD_REQ;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_RD_REQ:  w_next_state = S_RD_WAIT;
      S_RD_WAIT: begin
        // bits 6:4 are masked so they cannot defeat the hold-key suppression
        w_code_next  = {rdata[7], 3'b000, rdata[3:0]};
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_last_valid_next = r_code[7];
        w_last_code_next  = r_code;
        if (w_accept) begin
          if (w_key <= 4'd9) begin
            w_disp_next = {display_value[27:0], w_key};
            w_kc_next   = key_count + 8'd1;
          end else if (w_key == 4'hA) begin
            w_disp_next = '0;
            w_kc_next   = key_count + 8'd1;
          end else if (w_key == 4'hB) begin
            w_disp_next = display_value >> 4;
            w_kc_next   = key_count + 8'd1;
          end
        end
        w_next_state = (w_disp_next != display_value) ? S_WR : S_IDLE;
      end
      S_WR:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase

    // address/strobe are registered copies keyed off the state being entered
    case (w_next_state)
      S_RD_REQ, S_RD_WAIT: w_addr_next = KEY_ADDR;
      S_WR: begin
        w_addr_next  = DISP_ADDR;
        w_wdata_next = w_disp_next;
        w_we_next    = 1'b1;
      end
      default: w_addr_next = IDLE_ADDR;
    endcase
  end

endmodule

// File: tb/tb_keypad_display_master.sv
// tb/tb_keypad_display_master.sv - directed self-checking bench for keypad_display_master
module tb_keypad_display_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  address;
  logic [31:0] wdata;
  logic        writeEnable;
  logic [31:0] rdata = '0;
  logic [31:0] display_value;
  logic [7:0]  key_count;
  logic        busy;

  logic [31:0] key_val = '0;
  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int wr_long  = 0;
  int poll_cnt = 0;
  int e_wr     = 0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_waddr = '0;
  logic        we_prev    = 1'b0;
  logic        busy_prev  = 1'b0;

  keypad_display_master #(.POLL_INTERVAL(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .address(address), .wdata(wdata),
    .writeEnable(writeEnable), .rdata(rdata), .display_value(display_value),
    .key_count(key_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // registered responder: dout follows the keypad register one edge after the address
  always @(posedge clk) if (address == 4'h0) rdata <= key_val;

  always @(negedge clk) begin
    if (writeEnable) begin
      wr_cnt++;
      last_wdata = wdata;
      last_waddr = address;
      if (we_prev) wr_long++;
    end
    we_prev = writeEnable;
    if (busy && !busy_prev) poll_cnt++;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 10) begin @(negedge clk); t++; end
    check("poll_end_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] kv, input logic [31:0] exp_disp,
                      input logic [7:0] exp_kc, input bit wrote);
    int t = 0;
    key_val = kv;
    while (!busy && t < 40) begin @(negedge clk); t++; end
    check("poll_start_busy", {31'b0, busy}, 32'h1);
    wait_idle();
    if (wrote) e_wr++;
    check("write_count", wr_cnt, e_wr);
    check("display_value", display_value, exp_disp);
    check("key_count", {24'b0, key_count}, {24'b0, exp_kc});
    if (wrote) begin
      check("write_data", last_wdata, exp_disp);
      check("write_addr", {28'b0, last_waddr}, 32'h4);
    end
  endtask

  logic [31:0] wrap_exp [9] = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345,
                                32'h123456, 32'h1234567, 32'h12345678, 32'h23456789};
  int p0;
  int t;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_address", {28'b0, address}, 32'hF);
    check("rst_wdata", wdata, 32'h0);
    check("rst_we", {31'b0, writeEnable}, 32'h0);
    check("rst_display", display_value, 32'h0);
    check("rst_key_count", {24'b0, key_count}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    enable = 1'b1;

    step(32'h85, 32'h5, 8'd1, 1'b1);
    step(32'h85, 32'h5, 8'd1, 1'b0);
    step(32'h00, 32'h5, 8'd1, 1'b0);
    step(32'h83, 32'h53, 8'd2, 1'b1);
    step(32'h00, 32'h53, 8'd2, 1'b0);
    step(32'h83, 32'h533, 8'd3, 1'b1);
    step(32'h8A, 32'h0, 8'd4, 1'b1);
    for (int i = 0; i < 9; i++)
      step(32'h81 + 32'(i), wrap_exp[i], 8'(5 + i), 1'b1);
    step(32'h8A, 32'h0, 8'd14, 1'b1);
    step(32'h81, 32'h1, 8'd15, 1'b1);
    step(32'h82, 32'h12, 8'd16, 1'b1);
    step(32'h83, 32'h123, 8'd17, 1'b1);
    step(32'h8B, 32'h12, 8'd18, 1'b1);
    step(32'h8A, 32'h0, 8'd19, 1'b1);
    step(32'h00, 32'h0, 8'd19, 1'b0);
    step(32'h8A, 32'h0, 8'd20, 1'b0);
    step(32'h87, 32'h7, 8'd21, 1'b1);
    step(32'hABCDEFF7, 32'h7, 8'd21, 1'b0);
    step(32'h8E, 32'h7, 8'd21, 1'b0);

    // drop enable while the read request is on the bus
    key_val = 32'h84;
    t = 0;
    while (address != 4'h0 && t < 40) begin @(negedge clk); t++; end
    check("rdreq_seen", {28'b0, address}, 32'h0);
    enable = 1'b0;
    wait_idle();
    e_wr++;
    check("drop_write_count", wr_cnt, e_wr);
    check("drop_write_data", last_wdata, 32'h74);
    check("drop_key_count", {24'b0, key_count}, 32'd22);
    p0 = poll_cnt;
    repeat (30) @(negedge clk);
    #1;
    check("disabled_no_poll", poll_cnt, p0);
    check("disabled_address", {28'b0, address}, 32'hF);
    enable = 1'b1;
    step(32'h85, 32'h745, 8'd23, 1'b1);
    check("we_single_cycle", wr_long, 0);

    // asynchronous reset in the middle of RD_WAIT
    key_val = 32'h86;
    t = 0;
    while (address != 4'h0 && t < 40) begin @(negedge clk); t++; end
    check("rdreq_seen2", {28'b0, address}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_address", {28'b0, address}, 32'hF);
    check("async_rst_we", {31'b0, writeEnable}, 32'h0);
    check("async_rst_display", display_value, 32'h0);
    check("async_rst_key_count", {24'b0, key_count}, 32'h0);
    check("async_rst_wdata", wdata, 32'h0);
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
